// File: rtl/vmac_pkg.sv
// Shared definitions for the vector MAC issue scheduler.
// Contents: default element/vector geometry and MAC latency, the tag-pipe
// entry type, and the requester-id width helper.
package vmac_pkg;

    localparam int unsigned DEF_E_WIDTH = 8;
    localparam int unsigned DEF_M_WIDTH = 7;
    localparam int unsigned DEF_VECTOR  = 8;
    localparam int unsigned DEF_MAC_LAT = 2;

    // Widest id ever needed (NREQ <= 8); narrower builds use the low bits.
    localparam int unsigned MAX_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    function automatic int unsigned vmac_idw(input int unsigned nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/vmac_rsp_fifo.sv
// Circular FIFO holding {id, data} result entries for vmac_scheduler.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and entry
//   pop, pop_data     read request and head entry (zero while empty)
//   full, empty       occupancy flags
//   count             number of stored entries
module vmac_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem_q[rd_q];

    // Storage is left unreset; pop_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vmac_scheduler.sv
// Issue controller and arbiter sharing one vector_mac between NREQ requesters.
// Grants at most one operand triple per cycle, drives it onto mac_a/b/c,
// tracks the MAC latency with a tag pipe and returns results, tagged with the
// requester id, in grant order through a credit-protected FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (ready is the grant)
//   req_a, req_b, req_c      operand triples, requester i at [VLEN*i +: VLEN]
//   mac_a, mac_b, mac_c      operand bus to vector_mac (zero when idle)
//   mac_out                  vector_mac result, valid MAC_LAT cycles after issue
//   rsp_valid / rsp_ready    result handshake
//   rsp_data, rsp_id         result vector and originating requester
//   busy                     a tag is in flight or the FIFO holds results
// Build option: define VMAC_SCHED_PRIO_EN to give requester 0 strict
// priority, with round-robin among the remaining requesters.
module vmac_scheduler
    import vmac_pkg::*;
#(
    parameter int unsigned E_WIDTH    = DEF_E_WIDTH,
    parameter int unsigned M_WIDTH    = DEF_M_WIDTH,
    parameter int unsigned VECTOR     = DEF_VECTOR,
    parameter int unsigned I_WIDTH    = E_WIDTH + M_WIDTH + 1,
    parameter int unsigned VLEN       = I_WIDTH * VECTOR,
    parameter int unsigned NREQ       = 2,
    parameter int unsigned MAC_LAT    = DEF_MAC_LAT,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDW       = vmac_idw(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*VLEN-1:0] req_a,
    input  logic [NREQ*VLEN-1:0] req_b,
    input  logic [NREQ*VLEN-1:0] req_c,
    output logic [VLEN-1:0]      mac_a,
    output logic [VLEN-1:0]      mac_b,
    output logic [VLEN-1:0]      mac_c,
    input  logic [VLEN-1:0]      mac_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [VLEN-1:0]      rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LAST = MAC_LAT - 1;

    logic [IDW-1:0]     rr_q;
    logic [IDW-1:0]     rr_next;
    logic [IDW:0]       scan_sum;
    logic [IDW-1:0]     scan_id;
    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic               issue_en;
    logic [CW-1:0]      inflight_q;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        credit;
    logic               fifo_empty;
    logic               unused_fifo_full;
    logic               push;
    logic               pop;
    logic [MAX_IDW-1:0] last_id;
    logic               unused_last_id;
    logic [IDW+VLEN-1:0] fifo_head;
    tag_t               tag_in;
    tag_t               tag_q [MAC_LAT];

    // Both counts are registered, so a pop only frees credit next cycle.
    assign credit   = (CW+1)'(FIFO_DEPTH) - ({1'b0, fifo_count} + {1'b0, inflight_q});
    assign issue_en = (credit != '0) && !rst && grant_found;

    // Round-robin scan starting at rr_q; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_sum    = '0;
        scan_id     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_q} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            end
            scan_id = scan_sum[IDW-1:0];
`ifdef VMAC_SCHED_PRIO_EN
            if (!grant_found && scan_id != '0 && req_valid[scan_id]) begin
`else
            if (!grant_found && req_valid[scan_id]) begin
`endif
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
`ifdef VMAC_SCHED_PRIO_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_id    = '0;
        end
`endif
    end

    assign rr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    // Grant decode and operand mux.
    always_comb begin
        req_ready = '0;
        mac_a     = '0;
        mac_b     = '0;
        mac_c     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue_en && grant_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                mac_a        = req_a[VLEN*i +: VLEN];
                mac_b        = req_b[VLEN*i +: VLEN];
                mac_c        = req_c[VLEN*i +: VLEN];
            end
        end
    end

    always_comb begin
        tag_in.valid = issue_en;
        tag_in.id    = issue_en ? MAX_IDW'(grant_id) : '0;
    end

    // Stage k holds the tag issued k+1 cycles ago, so the last stage lines
    // up with the cycle in which mac_out is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MAC_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int s = 1; s < MAC_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign last_id        = tag_q[LAST].id;
    assign unused_last_id = ^last_id;
    assign push           = tag_q[LAST].valid;
    assign pop            = rsp_ready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            inflight_q <= '0;
        end else begin
            if (issue_en) begin
                rr_q <= rr_next;
            end
            case ({issue_en, push})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    vmac_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDW + VLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({last_id[IDW-1:0], mac_out}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid          = !fifo_empty;
    assign {rsp_id, rsp_data} = fifo_head;
    assign busy               = (inflight_q != '0) || !fifo_empty;

endmodule

// File: tb/tb_vmac_scheduler.sv
// Self-checking bench for vmac_scheduler with a behavioural bf16 vector MAC
// (a*b+c per lane, MAC_LAT cycles) standing in for vector_mac.
module tb_vmac_scheduler;

    localparam int unsigned NREQ       = 2;
    localparam int unsigned VECTOR     = 8;
    localparam int unsigned VLEN       = 16 * VECTOR;
    localparam int unsigned IDW        = 1;
    localparam int unsigned MAC_LAT    = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*VLEN-1:0] req_a, req_b, req_c;
    logic [VLEN-1:0]      mac_a, mac_b, mac_c, mac_out;
    logic                 rsp_valid, rsp_ready;
    logic [VLEN-1:0]      rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    vmac_scheduler #(
        .E_WIDTH    (8),
        .M_WIDTH    (7),
        .VECTOR     (VECTOR),
        .NREQ       (NREQ),
        .MAC_LAT    (MAC_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_out   (mac_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int grants = 0;
    int pops   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [VLEN-1:0] got,
                         input logic [VLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // bf16 <-> real via IEEE double; subnormals treated as zero.
    function automatic real bf2r(input logic [15:0] h);
        logic [63:0] d;
        if (h[14:7] == 8'd0) d = {h[15], 63'b0};
        else d = {h[15], 11'(h[14:7]) - 11'd127 + 11'd1023, h[6:0], 45'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 15'b0};
        e = d[62:52];
        return {d[63], 8'(e - 11'd1023 + 11'd127), d[51:45]};
    endfunction

    function automatic logic [VLEN-1:0] vfma(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                             input logic [VLEN-1:0] c);
        logic [VLEN-1:0] r;
        r = '0;
        for (int k = 0; k < VECTOR; k++) begin
            r[16*k +: 16] = r2bf(bf2r(a[16*k +: 16]) * bf2r(b[16*k +: 16]) + bf2r(c[16*k +: 16]));
        end
        return r;
    endfunction

    function automatic logic [VLEN-1:0] make_vec(input logic [15:0] even, input logic [15:0] odd);
        logic [VLEN-1:0] v;
        v = '0;
        for (int k = 0; k < VECTOR; k++) v[16*k +: 16] = (k % 2 == 1) ? odd : even;
        return v;
    endfunction

    task automatic set_req(input int r, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                           input logic [VLEN-1:0] c);
        for (int i = 0; i < NREQ; i++) begin
            if (i == r) begin
                req_a[VLEN*i +: VLEN] = a;
                req_b[VLEN*i +: VLEN] = b;
                req_c[VLEN*i +: VLEN] = c;
            end
        end
    endtask

    // Behavioural vector_mac.
    logic [VLEN-1:0] mac_pipe [MAC_LAT];
    always @(posedge clk) begin
        mac_pipe[0] <= vfma(mac_a, mac_b, mac_c);
        for (int s = 1; s < MAC_LAT; s++) mac_pipe[s] <= mac_pipe[s-1];
    end
    assign mac_out = mac_pipe[MAC_LAT-1];

    // Scoreboard: expectation pushed on each grant, popped on each response.
    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [VLEN-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (req_valid != '0) begin
                check("ready_only_on_valid", VLEN'(req_ready & ~req_valid), '0);
                check("ready_at_most_one", VLEN'($countones(req_ready) > 1), '0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grants++;
                    grant_log.push_back(i);
                    sb_q.push_back('{id: IDW'(i),
                                     data: vfma(req_a[VLEN*i +: VLEN], req_b[VLEN*i +: VLEN],
                                                req_c[VLEN*i +: VLEN])});
                end
            end
            if (rsp_valid && rsp_ready) begin
                pops++;
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", VLEN'(1), VLEN'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_rsp_id", VLEN'(rsp_id), VLEN'(e.id));
                    check("sb_rsp_data", rsp_data, e.data);
                end
            end
            if (dut.u_fifo.push) begin
                check("push_when_full", VLEN'(dut.u_fifo.full), '0);
            end
        end
    end

    typedef struct {
        int          req;
        logic [15:0] a, b, c_even, c_odd, exp_even, exp_odd;
    } vec_t;

    vec_t tbl[6];

    task automatic drain(input string name);
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, VLEN'(busy), '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc, got, t_acc, g0, p0, nrsp;

        tbl[0] = '{0, 16'h3F80, 16'h4000, 16'h3F80, 16'h3F80, 16'h4040, 16'h4040};
        tbl[1] = '{1, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0000, 16'h4000, 16'h3F80};
        tbl[2] = '{0, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4080, 16'h4080};
        tbl[3] = '{1, 16'h4040, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4080, 16'h4080};
        tbl[4] = '{0, 16'h0000, 16'h4040, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
        tbl[5] = '{1, 16'h4000, 16'h4040, 16'h0000, 16'h0000, 16'h40C0, 16'h40C0};

        // Reset with both requesters valid: nothing may be granted.
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        set_req(0, make_vec(16'h3F80, 16'h3F80), make_vec(16'h3F80, 16'h3F80), '0);
        set_req(1, make_vec(16'h4000, 16'h4000), make_vec(16'h4000, 16'h4000), '0);
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", VLEN'(req_ready), '0);
        check("reset_rsp_valid", VLEN'(rsp_valid), '0);
        check("reset_rsp_data", rsp_data, '0);
        check("reset_rsp_id", VLEN'(rsp_id), '0);
        check("reset_busy", VLEN'(busy), '0);
        check("reset_mac_a", mac_a, '0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single ops, one at a time: latency, data, id and busy timing.
        for (int v = 0; v < 6; v++) begin
            set_req(tbl[v].req, make_vec(tbl[v].a, tbl[v].a), make_vec(tbl[v].b, tbl[v].b),
                    make_vec(tbl[v].c_even, tbl[v].c_odd));
            req_valid = '0;
            req_valid[tbl[v].req] = 1'b1;
            acc   = 0;
            t_acc = 0;
            for (int w = 0; w < 10 && acc == 0; w++) begin
                @(negedge clk);
                if (req_ready[tbl[v].req]) begin
                    acc   = 1;
                    t_acc = cyc;
                end
                @(posedge clk);
                #1;
            end
            req_valid = '0;
            check("vec_accept", VLEN'(acc), VLEN'(1));
            got = 0;
            for (int w = 0; w < 10 && got == 0; w++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    got = 1;
                    check("vec_latency", VLEN'(cyc - t_acc), VLEN'(MAC_LAT + 1));
                    check("vec_data", rsp_data, make_vec(tbl[v].exp_even, tbl[v].exp_odd));
                    check("vec_id", VLEN'(rsp_id), VLEN'(tbl[v].req));
                    check("vec_busy_high", VLEN'(busy), VLEN'(1));
                end
            end
            check("vec_rsp_seen", VLEN'(got), VLEN'(1));
            @(negedge clk);
            check("vec_busy_fall", VLEN'(busy), '0);
            @(posedge clk);
            #1;
        end

        // Contention: both valid for 8 cycles.
        set_req(0, make_vec(16'h3F80, 16'h3F80), make_vec(16'h4000, 16'h4000),
                make_vec(16'h3F80, 16'h3F80));
        set_req(1, make_vec(16'h4000, 16'h4000), make_vec(16'h4000, 16'h4000), '0);
        grant_log.delete();
        req_valid = 2'b11;
        repeat (8) @(posedge clk);
        #1;
        req_valid = '0;
        check("contention_grants", VLEN'(grant_log.size()), VLEN'(8));
        for (int k = 0; k < grant_log.size(); k++) begin
`ifdef VMAC_SCHED_PRIO_EN
            check("contention_order", VLEN'(grant_log[k]), '0);
`else
            check("contention_order", VLEN'(grant_log[k]), VLEN'(k % 2));
`endif
        end
        drain("contention_drain");

        // Backpressure: credit limits acceptance to FIFO_DEPTH.
        rsp_ready = 1'b0;
        g0        = grants;
        req_valid = 2'b01;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", VLEN'(grants - g0), VLEN'(FIFO_DEPTH));
        check("bp_ready_low", VLEN'(req_ready), '0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        p0        = pops;
        g0        = grants;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_one_pop", VLEN'(pops - p0), VLEN'(1));
        check("bp_one_grant", VLEN'(grants - g0), VLEN'(1));
        check("bp_ready_low_again", VLEN'(req_ready), '0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        drain("bp_drain");

        // Reset one cycle after a grant: the op is dropped, pointer restarts.
        set_req(0, make_vec(16'h3F80, 16'h3F80), make_vec(16'h4000, 16'h4000),
                make_vec(16'h3F80, 16'h3F80));
        req_valid = 2'b01;
        @(negedge clk);
        check("rst_pre_grant", VLEN'(req_ready), VLEN'(2'b01));
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        nrsp = 0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        check("rst_no_rsp", VLEN'(nrsp), '0);
        check("rst_busy", VLEN'(busy), '0);
        @(posedge clk);
        #1;
        set_req(1, make_vec(16'h4000, 16'h4000), make_vec(16'h4000, 16'h4000), '0);
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_next_grant", VLEN'(req_ready), VLEN'(2'b01));
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("final_drain");
        check("sb_empty", VLEN'(sb_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
